// File: rtl/memory_arbiter_if.sv
// Bus bundle between the fetch/LSU requesters, the arbiter and the memory slave.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface memory_arbiter_if;
  logic [2:0]  r0Command;
  logic [2:0]  r1Command;
  logic [31:0] r0Address;
  logic [31:0] r1Address;
  logic [31:0] r0Data;
  logic [31:0] r1Data;
  logic        r0Done;
  logic        r1Done;
  logic [31:0] r0Result;
  logic [31:0] r1Result;
  logic        r0Signal;
  logic        r1Signal;
  logic [2:0]  cCommand;
  logic [31:0] cAddress;
  logic [31:0] cData;
  logic        hReady;
  logic        hSignal;
  logic [31:0] hData;
  logic        grant;
  logic        busy;

  modport slave (
    input  r0Command, r1Command, r0Address, r1Address, r0Data, r1Data,
    input  hReady, hSignal, hData,
    output r0Done, r1Done, r0Result, r1Result, r0Signal, r1Signal,
    output cCommand, cAddress, cData, grant, busy
  );

  modport master (
    output r0Command, r1Command, r0Address, r1Address, r0Data, r1Data,
    output hReady, hSignal, hData,
    input  r0Done, r1Done, r0Result, r1Result, r0Signal, r1Signal,
    input  cCommand, cAddress, cData, grant, busy
  );
endinterface

// File: rtl/memory_arbiter.sv
// Two-port arbiter sharing one memory slave: IDLE -> ISSUE -> WAIT -> RELEASE per transaction.
// Define MEMORY_ARBITER_FIXED_PRIORITY_EN to make port 0 always win contention (default: round-robin).
module memory_arbiter (
  input  logic             clock,
  input  logic             reset,
  memory_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

  localparam logic [2:0] CMD_NOP = 3'b000;

  state_t           r_state, w_state_next;
  logic             r_grant, w_grant_next;
  logic             r_busy;
  logic [2:0]       r_cmd, w_cmd_next;
  logic [31:0]      r_addr, w_addr_next;
  logic [31:0]      r_data, w_data_next;
  logic [1:0]       r_done, w_done_next;
  logic [1:0][31:0] r_result, w_result_next;
  logic [1:0]       r_signal, w_signal_next;

  logic w_req0, w_req1, w_any_req, w_winner;

  assign w_req0    = (bus.r0Command != CMD_NOP);
  assign w_req1    = (bus.r1Command != CMD_NOP);
  assign w_any_req = w_req0 | w_req1;

`ifdef MEMORY_ARBITER_FIXED_PRIORITY_EN
  assign w_winner = ~w_req0;
`else
  logic r_last_grant;

  // Under contention the port that did not win last time goes first.
  assign w_winner = (w_req0 && w_req1) ? ~r_last_grant : w_req1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_last_grant <= 1'b1;
    else if (r_state == IDLE && w_any_req)
      r_last_grant <= w_winner;
  end
`endif

  always_comb begin
    w_state_next  = r_state;
    w_grant_next  = r_grant;
    w_cmd_next    = r_cmd;
    w_addr_next   = r_addr;
    w_data_next   = r_data;
    w_done_next   = 2'b00;
    w_result_next = r_result;
    w_signal_next = r_signal;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_next = ISSUE;
          w_grant_next = w_winner;
          w_cmd_next   = w_winner ? bus.r1Command : bus.r0Command;
          w_addr_next  = w_winner ? bus.r1Address : bus.r0Address;
          w_data_next  = w_winner ? bus.r1Data    : bus.r0Data;
        end
      end
      // hReady still reflects the previous operation here, so it is not looked at.
      ISSUE: w_state_next = WAIT;
      WAIT: begin
        if (bus.hReady) begin
          w_result_next[r_grant] = bus.hData;
          w_signal_next[r_grant] = bus.hSignal;
          w_done_next[r_grant]   = 1'b1;
          w_cmd_next             = CMD_NOP;
          w_state_next           = RELEASE;
        end
      end
      RELEASE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_grant  <= 1'b0;
      r_busy   <= 1'b0;
      r_cmd    <= CMD_NOP;
      r_addr   <= '0;
      r_data   <= '0;
      r_done   <= '0;
      r_result <= '0;
      r_signal <= '0;
    end else begin
      r_state  <= w_state_next;
      r_grant  <= w_grant_next;
      r_busy   <= (w_state_next != IDLE);
      r_cmd    <= w_cmd_next;
      r_addr   <= w_addr_next;
      r_data   <= w_data_next;
      r_done   <= w_done_next;
      r_result <= w_result_next;
      r_signal <= w_signal_next;
    end
  end

  assign bus.cCommand = r_cmd;
  assign bus.cAddress = r_addr;
  assign bus.cData    = r_data;
  assign bus.grant    = r_grant;
  assign bus.busy     = r_busy;
  assign bus.r0Done   = r_done[0];
  assign bus.r1Done   = r_done[1];
  assign bus.r0Result = r_result[0];
  assign bus.r1Result = r_result[1];
  assign bus.r0Signal = r_signal[0];
  assign bus.r1Signal = r_signal[1];
endmodule
